inst_sequencer: RTL and testbench
=================================

// Module: inst_sequencer
// PURPOSE
//  Parametrised multi-cycle instruction decoder/sequencer, successor to the single-cycle decoder.
//  Accepts 32-bit instruction words over a valid/ready handshake and evaluates the condition field.
//  Drives the external register file and ALU, owns the flags register, and adds iterative MUL/DIV.
//  Sits between fetch (cpu_core) and reg_file/alu inside the cpu top.
// PARAMETERS
//  DATA_W    8  datapath width; arg immediates are zero-extended to DATA_W
//  NUM_REGS  4  register count, power of 2 >= 2; RSEL_W = $clog2(NUM_REGS)
//  ADDR_W    8  jump address width; taken from the low ADDR_W bits of arg1 or of the register value
// PORTS
//  clk          in   1        clock
//  reset        in   1        synchronous, active-low reset
//  ir           in   32       [31:27] cond, [26:24] super, [23:20] sub, [19:16] funct, [15:8] arg1, [7:0] arg2
//  ir_valid     in   1        instruction present on ir
//  ir_ready     out  1        high only in IDLE; transfer when ir_valid & ir_ready
//  ra_sel       out  RSEL_W   read port A select (comb. data on ra_data)
//  ra_data      in   DATA_W   read port A data
//  rb_sel       out  RSEL_W   read port B select
//  rb_data      in   DATA_W   read port B data
//  reg_w        out  1        register write strobe, one cycle per write
//  reg_w_sel    out  RSEL_W   write select
//  reg_w_data   out  DATA_W   write data
//  alu_a/alu_b  out  DATA_W   ALU operands
//  alu_op       out  4        ALU op = funct
//  alu_c        in   DATA_W   ALU result
//  alu_flags    in   8        ALU flags {2'b0,VF,PF,SF,ZF,AF,CF}
//  jmp          out  1        one-cycle jump pulse
//  jmp_addr     out  ADDR_W   jump target, valid with jmp
//  hlt          out  1        level, set in HALT
//  illegal      out  1        one-cycle pulse on illegal instruction
//  busy         out  1        state != IDLE
//  flags        out  8        architectural flags register
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, flags=0, ir_q=0, MUL/DIV regs=0. All strobes, hlt and busy read 0;
//   ir_ready=0 while reset is low. reset low in any state, including mid MUL/DIV, aborts with no writes.
//  States: IDLE -> EXEC -> {IDLE | MD | HALT}; MD -> WB_LO -> WB_HI -> IDLE; HALT stays until reset.
//  IDLE: ir_ready=1. On handshake, latch ir into ir_q and go to EXEC.
//  EXEC (1 cycle): evaluate cond on flags. Encoding: 0 always; 1 Z; 2 NZ; 3 S; 4 NS; 5 G=~(ZF|(SF^VF));
//   6 GE; 7 L; 8 LE; 9 A=~(ZF|CF); 10 NC; 11 C; 12 BE; 13 V; 14 NV; 15 P; 16 NP; 17 HC(AF); 18 NHC.
//   Codes 19..31 are illegal.
//  Illegal: undefined cond, super==0 with funct>7, or a register arg >= NUM_REGS.
//   Response: pulse illegal in EXEC, no side effects, return to IDLE.
//  A false condition skips the instruction: no side effects, return to IDLE.
//  super==0 opcodes; each completes in EXEC unless noted:
//   0 NOP. 1 HLT -> HALT. 2 JMP imm: jmp=1, jmp_addr=arg1. 3 JMP reg: jmp_addr=ra_data[ADDR_W-1:0].
//   4 MOV r,imm. 5 MOV r,r.
//   6 MUL a1,a2: 2*DATA_W product; low half -> r[a1], high half -> r[(a1+1) mod NUM_REGS].
//   7 DIV a1,a2: quotient -> r[a1], remainder -> r[(a1+1) mod NUM_REGS].
//  super!=0, sub!=0: r[a1] <= alu(r[a1], imm a2). super!=0, sub==0: r[a1] <= alu(r[a1], r[a2]).
//   ALU ops: reg_w in EXEC and flags<=alu_flags at the end of EXEC.
//  MUL/DIV: operands latched at the end of EXEC, then MD runs DATA_W cycles (shift-add; restoring divide).
//   WB_LO writes the low half/quotient; WB_HI writes the high half/remainder.
//   flags update at the end of WB_HI.
//  Latency: single-cycle instruction ready again 2 cycles after accept; MUL/DIV in DATA_W+4.
//  MUL flags: ZF=(product==0), CF=VF=(hi!=0), SF=lo[MSB], PF=even parity(lo), AF=0.
//  DIV flags: ZF=(q==0), SF=q[MSB], PF=parity(q), CF=VF=AF=0.
//  DIV by zero: detected in EXEC; no MD, no writes; VF<=1, other flags kept; return to IDLE.
//  Write-port aliasing: a1==a2 or the high-half destination == a2 is legal (operands already latched).
// TESTING
//  MUL r0(0xFF),r1(0xFF), DATA_W=8 -> reg_w r0=0x01, next cycle r1=0xFE; CF=VF=1, ZF=0; ready at +12.
//  MUL arg1=3, r3=0x10, r2=0x20 -> r3=0x00, r0=0x02; ZF=0, CF=1 (hi-half index wraps).
//  DIV r0(0x64),r2(0x07) -> r0=0x0E, r1=0x02; DIV r0,r2 with r2=0 -> no reg_w, VF=1, ready in 2 cycles.
//  flags ZF=0: cond=2 JMP 0x40 -> jmp pulse, addr 0x40; cond=1 JMP -> no jmp, ir_ready after 2 cycles.
//  cond=0x1F, or MOV with arg1=5 and NUM_REGS=4 -> illegal pulse, no reg_w, flags unchanged.
//  reset=0 in cycle 3 of MD -> next cycle IDLE, no reg_w, flags=0; HLT -> hlt=1 held, ir_ready=0.

Source files
------------

// File: rtl/inst_sequencer.sv
// inst_sequencer: multi-cycle instruction decoder/sequencer.
// Takes 32-bit instruction words over a valid/ready handshake and checks the
// condition field against the flags register. It drives the external register
// file and ALU, owns the flags register, and runs MUL/DIV iteratively
// (shift-add multiply, restoring divide).
//
// Handshake: an instruction transfers on a rising clk edge where
// ir_valid && ir_ready. ir_ready is high only in IDLE while reset is high.
// The word is latched into ir_q, so the producer may change ir after the
// transfer edge.
module inst_sequencer #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 8,
    localparam int RSEL_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ir,
    input  logic              ir_valid,
    output logic              ir_ready,
    output logic [RSEL_W-1:0] ra_sel,
    input  logic [DATA_W-1:0] ra_data,
    output logic [RSEL_W-1:0] rb_sel,
    input  logic [DATA_W-1:0] rb_data,
    output logic              reg_w,
    output logic [RSEL_W-1:0] reg_w_sel,
    output logic [DATA_W-1:0] reg_w_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_c,
    input  logic [7:0]        alu_flags,
    output logic              jmp,
    output logic [ADDR_W-1:0] jmp_addr,
    output logic              hlt,
    output logic              illegal,
    output logic              busy,
    output logic [7:0]        flags,
    output logic [2:0]        dbg_state_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC  = 3'd1,
        S_MD    = 3'd2,
        S_WB_LO = 3'd3,
        S_WB_HI = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [31:0]       ir_q;
    logic [7:0]        flags_q;
    logic [DATA_W-1:0] md_hi_q;   // product high half / partial remainder
    logic [DATA_W-1:0] md_lo_q;   // multiplier then product low half / dividend then quotient
    logic [DATA_W-1:0] md_op_q;   // multiplicand / divisor
    logic [CNT_W-1:0]  md_cnt_q;
    logic              md_div_q;

    // Instruction fields of the latched word
    logic [4:0]        f_cond;
    logic [2:0]        f_super;
    logic [3:0]        f_sub;
    logic [3:0]        f_funct;
    logic [7:0]        f_a1;
    logic [7:0]        f_a2;
    logic [RSEL_W-1:0] a1_sel;
    logic [RSEL_W-1:0] a2_sel;
    logic [DATA_W-1:0] imm_a2;

    assign f_cond  = ir_q[31:27];
    assign f_super = ir_q[26:24];
    assign f_sub   = ir_q[23:20];
    assign f_funct = ir_q[19:16];
    assign f_a1    = ir_q[15:8];
    assign f_a2    = ir_q[7:0];
    assign a1_sel  = f_a1[RSEL_W-1:0];
    assign a2_sel  = f_a2[RSEL_W-1:0];
    assign imm_a2  = DATA_W'(f_a2);

    // Condition codes evaluated against the architectural flags
    function automatic logic cond_eval(input logic [4:0] c, input logic [7:0] f);
        logic cf, af, zf, sf, pf, vf;
        cf = f[0];
        af = f[1];
        zf = f[2];
        sf = f[3];
        pf = f[4];
        vf = f[5];
        case (c)
            5'd0:    cond_eval = 1'b1;
            5'd1:    cond_eval = zf;
            5'd2:    cond_eval = ~zf;
            5'd3:    cond_eval = sf;
            5'd4:    cond_eval = ~sf;
            5'd5:    cond_eval = ~(zf | (sf ^ vf));
            5'd6:    cond_eval = ~(sf ^ vf);
            5'd7:    cond_eval = sf ^ vf;
            5'd8:    cond_eval = zf | (sf ^ vf);
            5'd9:    cond_eval = ~(zf | cf);
            5'd10:   cond_eval = ~cf;
            5'd11:   cond_eval = cf;
            5'd12:   cond_eval = cf | zf;
            5'd13:   cond_eval = vf;
            5'd14:   cond_eval = ~vf;
            5'd15:   cond_eval = pf;
            5'd16:   cond_eval = ~pf;
            5'd17:   cond_eval = af;
            5'd18:   cond_eval = ~af;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    // Decode: which args name registers, legality, and whether EXEC acts
    logic uses_a1, uses_a2, a1_ok, a2_ok;
    logic is_illegal, cond_true, exec_go;
    logic is_mul, is_div, div_zero;

    always_comb begin
        uses_a1 = 1'b0;
        uses_a2 = 1'b0;
        if (f_super == 3'd0) begin
            case (f_funct)
                4'd3, 4'd4:       uses_a1 = 1'b1;
                4'd5, 4'd6, 4'd7: begin
                    uses_a1 = 1'b1;
                    uses_a2 = 1'b1;
                end
                default: ;
            endcase
        end else begin
            uses_a1 = 1'b1;
            uses_a2 = (f_sub == 4'd0);
        end
        a1_ok      = ((f_a1 >> RSEL_W) == 8'd0);
        a2_ok      = ((f_a2 >> RSEL_W) == 8'd0);
        is_illegal = (f_cond > 5'd18)
                   || ((f_super == 3'd0) && (f_funct > 4'd7))
                   || (uses_a1 && !a1_ok)
                   || (uses_a2 && !a2_ok);
        cond_true  = cond_eval(f_cond, flags_q);
        exec_go    = (state_q == S_EXEC) && !is_illegal && cond_true;
        is_mul     = (f_super == 3'd0) && (f_funct == 4'd6);
        is_div     = (f_super == 3'd0) && (f_funct == 4'd7);
        div_zero   = is_div && (rb_data == '0);
    end

    // One MD iteration plus the flags produced at write-back
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W:0]   div_trial;
    logic [DATA_W-1:0] md_hi_step;
    logic [DATA_W-1:0] md_lo_step;
    logic [7:0]        md_flags;

    always_comb begin
        mul_sum    = {1'b0, md_hi_q} + (md_lo_q[0] ? {1'b0, md_op_q} : '0);
        div_shift  = {md_hi_q, md_lo_q[DATA_W-1]};
        div_trial  = div_shift - {1'b0, md_op_q};
        md_hi_step = mul_sum[DATA_W:1];
        md_lo_step = {mul_sum[0], md_lo_q[DATA_W-1:1]};
        if (md_div_q) begin
            if (!div_trial[DATA_W]) begin
                md_hi_step = div_trial[DATA_W-1:0];
                md_lo_step = (md_lo_q << 1) | DATA_W'(1);
            end else begin
                md_hi_step = div_shift[DATA_W-1:0];
                md_lo_step = md_lo_q << 1;
            end
        end
        if (md_div_q) begin
            md_flags = {2'b00, 1'b0, ~^md_lo_q, md_lo_q[DATA_W-1], ~|md_lo_q, 1'b0, 1'b0};
        end else begin
            md_flags = {2'b00, |md_hi_q, ~^md_lo_q, md_lo_q[DATA_W-1],
                        ~(|md_hi_q | |md_lo_q), 1'b0, |md_hi_q};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ir_valid) state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_IDLE;
                if (exec_go && (f_super == 3'd0)) begin
                    if (f_funct == 4'd1)              state_d = S_HALT;
                    else if (is_mul)                  state_d = S_MD;
                    else if (is_div && !div_zero)     state_d = S_MD;
                end
            end
            S_MD:    if (md_cnt_q == CNT_W'(DATA_W - 1)) state_d = S_WB_LO;
            S_WB_LO: state_d = S_WB_HI;
            S_WB_HI: state_d = S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: register-file/ALU drive, strobes and status
    always_comb begin
        ir_ready    = reset && (state_q == S_IDLE);
        busy        = (state_q != S_IDLE);
        hlt         = (state_q == S_HALT);
        flags       = flags_q;
        dbg_state_o = state_q;
        ra_sel      = a1_sel;
        rb_sel      = a2_sel;
        alu_a       = ra_data;
        alu_b       = (f_sub != 4'd0) ? imm_a2 : rb_data;
        alu_op      = f_funct;
        reg_w       = 1'b0;
        reg_w_sel   = a1_sel;
        reg_w_data  = '0;
        jmp         = 1'b0;
        jmp_addr    = '0;
        illegal     = (state_q == S_EXEC) && is_illegal;
        if (exec_go) begin
            if (f_super == 3'd0) begin
                case (f_funct)
                    4'd2: begin
                        jmp      = 1'b1;
                        jmp_addr = ADDR_W'(f_a1);
                    end
                    4'd3: begin
                        jmp      = 1'b1;
                        jmp_addr = ADDR_W'(ra_data);
                    end
                    4'd4: begin
                        reg_w      = 1'b1;
                        reg_w_data = imm_a2;
                    end
                    4'd5: begin
                        reg_w      = 1'b1;
                        reg_w_data = rb_data;
                    end
                    default: ;
                endcase
            end else begin
                reg_w      = 1'b1;
                reg_w_data = alu_c;
            end
        end
        if (state_q == S_WB_LO) begin
            reg_w      = 1'b1;
            reg_w_data = md_lo_q;
        end
        if (state_q == S_WB_HI) begin
            reg_w      = 1'b1;
            reg_w_sel  = a1_sel + RSEL_W'(1);
            reg_w_data = md_hi_q;
        end
        if (!reset) begin
            reg_w   = 1'b0;
            jmp     = 1'b0;
            illegal = 1'b0;
        end
    end

    // Datapath: instruction latch, flags and the MUL/DIV engine
    always_ff @(posedge clk) begin
        if (!reset) begin
            ir_q     <= '0;
            flags_q  <= '0;
            md_hi_q  <= '0;
            md_lo_q  <= '0;
            md_op_q  <= '0;
            md_cnt_q <= '0;
            md_div_q <= 1'b0;
        end else begin
            if ((state_q == S_IDLE) && ir_valid) begin
                ir_q <= ir;
            end
            if (exec_go) begin
                if (f_super != 3'd0) begin
                    flags_q <= alu_flags;
                end else if (div_zero) begin
                    flags_q[5] <= 1'b1;
                end else if (is_mul || is_div) begin
                    md_hi_q  <= '0;
                    md_lo_q  <= is_mul ? rb_data : ra_data;
                    md_op_q  <= is_mul ? ra_data : rb_data;
                    md_cnt_q <= '0;
                    md_div_q <= is_div;
                end
            end
            if (state_q == S_MD) begin
                md_hi_q  <= md_hi_step;
                md_lo_q  <= md_lo_step;
                md_cnt_q <= md_cnt_q + CNT_W'(1);
            end
            if (state_q == S_WB_HI) begin
                flags_q <= md_flags;
            end
        end
    end

endmodule

// File: tb/tb_inst_sequencer.sv
// Bench for inst_sequencer (DATA_W=8, NUM_REGS=4, ADDR_W=8). Models the
// external register file and a small ALU, applies a vector table and a few
// hand-written multi-cycle sequences, and checks register writes through an
// expected-write queue.
module tb_inst_sequencer;
  localparam int DATA_W = 8;
  localparam int NUM_REGS = 4;
  localparam int ADDR_W = 8;
  localparam int RSEL_W = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] ir = '0;
  logic ir_valid = 1'b0;
  logic ir_ready;
  logic [RSEL_W-1:0] ra_sel, rb_sel, reg_w_sel;
  logic [DATA_W-1:0] ra_data, rb_data, reg_w_data;
  logic reg_w;
  logic [DATA_W-1:0] alu_a, alu_b, alu_c;
  logic [3:0] alu_op;
  logic [7:0] alu_flags;
  logic jmp, hlt, illegal, busy;
  logic [ADDR_W-1:0] jmp_addr;
  logic [7:0] flags;
  logic [2:0] dbg_state_o;

  int n_checks = 0;
  int n_fail = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_e;
  logic [DATA_W-1:0] rf [NUM_REGS];

  inst_sequencer #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .ra_sel(ra_sel), .ra_data(ra_data), .rb_sel(rb_sel), .rb_data(rb_data),
    .reg_w(reg_w), .reg_w_sel(reg_w_sel), .reg_w_data(reg_w_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c), .alu_flags(alu_flags),
    .jmp(jmp), .jmp_addr(jmp_addr), .hlt(hlt), .illegal(illegal), .busy(busy),
    .flags(flags), .dbg_state_o(dbg_state_o)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // register file and ALU environment
  assign ra_data = rf[ra_sel];
  assign rb_data = rf[rb_sel];
  always @(posedge clk) if (reg_w) rf[reg_w_sel] <= reg_w_data;

  always_comb begin
    logic [8:0] r9;
    logic vf;
    r9 = '0;
    vf = 1'b0;
    case (alu_op)
      4'd0: begin
        r9 = {1'b0, alu_a} + {1'b0, alu_b};
        vf = (alu_a[7] == alu_b[7]) && (r9[7] != alu_a[7]);
      end
      4'd1: begin
        r9 = {1'b0, alu_a} - {1'b0, alu_b};
        vf = (alu_a[7] != alu_b[7]) && (r9[7] != alu_a[7]);
      end
      4'd2: r9 = {1'b0, alu_a & alu_b};
      4'd3: r9 = {1'b0, alu_a | alu_b};
      default: r9 = {1'b0, alu_a ^ alu_b};
    endcase
    alu_c = r9[7:0];
    alu_flags = {2'b00, vf, ~^r9[7:0], r9[7], r9[7:0] == 8'd0, 1'b0, r9[8]};
  end

  // scoreboard: every reg_w must match the head of the expected queue
  always @(negedge clk) begin
    if (reg_w) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_reg_w: got r%0d=0x%0h required no write", reg_w_sel, reg_w_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({reg_w_sel, reg_w_data} !== mon_e) begin
          n_fail++;
          $display("FAIL reg_w: got r%0d=0x%0h required r%0d=0x%0h",
                   reg_w_sel, reg_w_data, mon_e[9:8], mon_e[7:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] ir;
    int lat;
    logic [7:0] flg;
    int ill;
    int jn;
    logic [7:0] ja;
    int nw;
    logic [9:0] w0;
    logic [9:0] w1;
  } vec_t;

  vec_t tv[26];

  function automatic logic [31:0] mk(input logic [4:0] c, input logic [2:0] s, input logic [3:0] sb,
                                     input logic [3:0] f, input logic [7:0] a1, input logic [7:0] a2);
    return {c, s, sb, f, a1, a2};
  endfunction

  function automatic logic [9:0] wr(input logic [1:0] r, input logic [7:0] d);
    return {r, d};
  endfunction

  function automatic vec_t mkv(input logic [31:0] w, input int lat, input logic [7:0] flg, input int ill,
                               input int jn, input logic [7:0] ja, input int nw,
                               input logic [9:0] w0, input logic [9:0] w1);
    vec_t v;
    v.ir = w; v.lat = lat; v.flg = flg; v.ill = ill; v.jn = jn; v.ja = ja;
    v.nw = nw; v.w0 = w0; v.w1 = w1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // driver: apply one table entry and check latency, pulses, flags
  task automatic run_vec(input int i);
    int lat, ill_n, jmp_n, guard;
    logic [7:0] jaddr;
    if (tv[i].nw > 0) exp_q.push_back(tv[i].w0);
    if (tv[i].nw > 1) exp_q.push_back(tv[i].w1);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    ir = tv[i].ir;
    ir_valid = 1'b1;
    guard = 0;
    while (!ir_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("v%0d_accept", i), {31'd0, ir_ready}, 32'd1);
    @(posedge clk);
    #1;
    ir_valid = 1'b0;
    ir = $urandom;
    lat = 0; ill_n = 0; jmp_n = 0; jaddr = '0;
    do begin
      @(negedge clk);
      lat++;
      if (illegal) ill_n++;
      if (jmp) begin
        jmp_n++;
        jaddr = jmp_addr;
      end
    end while (!ir_ready && lat < 40);
    check($sformatf("v%0d_latency", i), lat, tv[i].lat);
    check($sformatf("v%0d_flags", i), {24'd0, flags}, {24'd0, tv[i].flg});
    check($sformatf("v%0d_illegal", i), ill_n, tv[i].ill);
    check($sformatf("v%0d_jmp", i), jmp_n, tv[i].jn);
    check($sformatf("v%0d_jmp_addr", i), {24'd0, jaddr}, {24'd0, tv[i].ja});
    check($sformatf("v%0d_writes_left", i), exp_q.size(), 0);
  endtask

  initial begin
    tv[0]  = mkv(mk(0, 0, 0, 4, 0, 8'hFF), 2, 8'h00, 0, 0, 0, 1, wr(0, 8'hFF), 0);
    tv[1]  = mkv(mk(0, 0, 0, 4, 1, 8'hFF), 2, 8'h00, 0, 0, 0, 1, wr(1, 8'hFF), 0);
    tv[2]  = mkv(mk(0, 0, 0, 6, 0, 1), 12, 8'h21, 0, 0, 0, 2, wr(0, 8'h01), wr(1, 8'hFE));
    tv[3]  = mkv(mk(0, 0, 0, 4, 3, 8'h10), 2, 8'h21, 0, 0, 0, 1, wr(3, 8'h10), 0);
    tv[4]  = mkv(mk(0, 0, 0, 4, 2, 8'h20), 2, 8'h21, 0, 0, 0, 1, wr(2, 8'h20), 0);
    tv[5]  = mkv(mk(0, 0, 0, 6, 3, 2), 12, 8'h31, 0, 0, 0, 2, wr(3, 8'h00), wr(0, 8'h02));
    tv[6]  = mkv(mk(0, 0, 0, 4, 0, 8'h64), 2, 8'h31, 0, 0, 0, 1, wr(0, 8'h64), 0);
    tv[7]  = mkv(mk(0, 0, 0, 4, 2, 8'h07), 2, 8'h31, 0, 0, 0, 1, wr(2, 8'h07), 0);
    tv[8]  = mkv(mk(0, 0, 0, 7, 0, 2), 12, 8'h00, 0, 0, 0, 2, wr(0, 8'h0E), wr(1, 8'h02));
    tv[9]  = mkv(mk(0, 0, 0, 4, 2, 8'h00), 2, 8'h00, 0, 0, 0, 1, wr(2, 8'h00), 0);
    tv[10] = mkv(mk(0, 0, 0, 7, 0, 2), 2, 8'h20, 0, 0, 0, 0, 0, 0);
    tv[11] = mkv(mk(2, 0, 0, 2, 8'h40, 0), 2, 8'h20, 0, 1, 8'h40, 0, 0, 0);
    tv[12] = mkv(mk(1, 0, 0, 2, 8'h40, 0), 2, 8'h20, 0, 0, 0, 0, 0, 0);
    tv[13] = mkv(mk(31, 0, 0, 0, 0, 0), 2, 8'h20, 1, 0, 0, 0, 0, 0);
    tv[14] = mkv(mk(0, 0, 0, 4, 5, 8'h11), 2, 8'h20, 1, 0, 0, 0, 0, 0);
    tv[15] = mkv(mk(0, 0, 0, 8, 0, 0), 2, 8'h20, 1, 0, 0, 0, 0, 0);
    tv[16] = mkv(mk(0, 0, 0, 5, 1, 0), 2, 8'h20, 0, 0, 0, 1, wr(1, 8'h0E), 0);
    tv[17] = mkv(mk(0, 0, 0, 3, 1, 0), 2, 8'h20, 0, 1, 8'h0E, 0, 0, 0);
    tv[18] = mkv(mk(0, 1, 1, 0, 1, 8'hF2), 2, 8'h15, 0, 0, 0, 1, wr(1, 8'h00), 0);
    tv[19] = mkv(mk(1, 0, 0, 4, 2, 8'h33), 2, 8'h15, 0, 0, 0, 1, wr(2, 8'h33), 0);
    tv[20] = mkv(mk(0, 1, 0, 1, 2, 0), 2, 8'h00, 0, 0, 0, 1, wr(2, 8'h25), 0);
    tv[21] = mkv(mk(11, 0, 0, 4, 3, 8'h01), 2, 8'h00, 0, 0, 0, 0, 0, 0);
    tv[22] = mkv(mk(5, 0, 0, 4, 3, 8'h77), 2, 8'h00, 0, 0, 0, 1, wr(3, 8'h77), 0);
    tv[23] = mkv(mk(0, 0, 0, 6, 2, 2), 12, 8'h31, 0, 0, 0, 2, wr(2, 8'h59), wr(3, 8'h05));
    tv[24] = mkv(mk(0, 0, 0, 7, 1, 2), 12, 8'h14, 0, 0, 0, 2, wr(1, 8'h00), wr(2, 8'h00));
    tv[25] = mkv(mk(0, 1, 0, 0, 1, 4), 2, 8'h14, 1, 0, 0, 0, 0, 0);

    // reset state
    reset = 1'b0;
    ir_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ir_ready", {31'd0, ir_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hlt", {31'd0, hlt}, 32'd0);
    check("rst_flags", {24'd0, flags}, 32'd0);
    check("rst_state", {29'd0, dbg_state_o}, 32'd0);
    ir_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, ir_ready}, 32'd1);

    for (int i = 0; i < 26; i++) run_vec(i);

    // reset during the third MD cycle of a MUL aborts with no writes
    @(negedge clk);
    check("mdrst_ready", {31'd0, ir_ready}, 32'd1);
    ir = mk(0, 0, 0, 6, 3, 3);
    ir_valid = 1'b1;
    @(posedge clk);
    #1;
    ir_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mdrst_in_md", {29'd0, dbg_state_o}, 32'd2);
    reset = 1'b0;
    @(negedge clk);
    check("mdrst_idle", {29'd0, dbg_state_o}, 32'd0);
    check("mdrst_busy", {31'd0, busy}, 32'd0);
    check("mdrst_flags", {24'd0, flags}, 32'd0);
    check("mdrst_ready_low", {31'd0, ir_ready}, 32'd0);
    reset = 1'b1;
    repeat (14) @(negedge clk);
    check("mdrst_after_ready", {31'd0, ir_ready}, 32'd1);
    check("mdrst_after_flags", {24'd0, flags}, 32'd0);

    // HLT holds until reset, ignoring further offered instructions
    ir = mk(0, 0, 0, 1, 0, 0);
    ir_valid = 1'b1;
    @(posedge clk);
    #1;
    ir = mk(0, 0, 0, 4, 0, 8'hAA);
    repeat (2) @(negedge clk);
    check("hlt_level", {31'd0, hlt}, 32'd1);
    check("hlt_busy", {31'd0, busy}, 32'd1);
    check("hlt_ready", {31'd0, ir_ready}, 32'd0);
    repeat (5) @(negedge clk);
    check("hlt_held", {31'd0, hlt}, 32'd1);
    check("hlt_state", {29'd0, dbg_state_o}, 32'd5);
    ir_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("hlt_cleared", {31'd0, hlt}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
